// File: rtl/fib_engine.sv
// Iterative recurrence engine: (a, b) <- (b, a (+) b) once per cycle for n steps,
// with wrap, saturating or modular addition and sticky overflow/error status.
module fib_engine #(
  parameter int W  = 32,
  parameter int NW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r_enable,
  input  logic [NW-1:0] init_n,
  input  logic [W-1:0]  init_a,
  input  logic [W-1:0]  init_b,
  input  logic [W-1:0]  init_m,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          w_enable,
  output logic [W-1:0]  result,
  output logic          ovf,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [NW-1:0] cnt;
  logic [W-1:0]  a, b, m;
  logic [1:0]    md;
  logic [W:0]    s;
  logic [W-1:0]  fs;
  logic          carry;
  logic          pre_err;

  always_comb begin
    s     = {1'b0, a} + {1'b0, b};
    fs    = s[W-1:0];
    carry = 1'b0;
    unique case (md)
      2'b01: begin
        fs    = s[W] ? '1 : s[W-1:0];
        carry = s[W];
      end
      // a, b < m so s < 2m: one conditional subtract reduces it, and the
      // difference always fits in W bits.
      2'b10: if (s >= {1'b0, m}) fs = s[W-1:0] - m;
      default: carry = s[W];
    endcase
  end

  assign pre_err = (mode == 2'b10) &&
                   ((init_m == '0) || (init_a >= init_m) || (init_b >= init_m));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = IDLE;
      RUN:  if (cnt == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (r_enable) state_nxt = RUN;
  end

  // An argument error runs as a zero-step job so the pulse lands one cycle
  // after start, with the result forced to zero on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a      <= '0;
      b      <= '0;
      m      <= '0;
      md     <= '0;
      result <= '0;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (r_enable) begin
        cnt <= pre_err ? '0 : init_n;
        a   <= init_a;
        b   <= init_b;
        m   <= init_m;
        md  <= mode;
        ovf <= 1'b0;
        err <= pre_err;
      end else if (state == RUN) begin
        if (cnt != '0) begin
          a   <= b;
          b   <= fs;
          cnt <= cnt - 1'b1;
          ovf <= ovf | carry;
        end else begin
          result <= err ? '0 : a;
        end
      end
    end
  end

  assign busy     = (state != IDLE);
  assign w_enable = (state == DONE);

endmodule

// File: tb/tb_fib_engine.sv
// Directed bench for fib_engine: a 32-bit and an 8-bit instance share control
// inputs; expected values are hand-computed Fibonacci terms.
module tb_fib_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r_enable = 1'b0;
  logic [31:0] init_n = '0;
  logic [31:0] init_a = '0, init_b = '0, init_m = '0;
  logic [1:0]  mode = 2'b00;

  logic        busy32, w_enable32, ovf32, err32;
  logic [31:0] result32;
  logic        busy8, w_enable8, ovf8, err8;
  logic [7:0]  result8;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  fib_engine #(.W(32), .NW(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .init_n(init_n),
    .init_a(init_a), .init_b(init_b), .init_m(init_m), .mode(mode),
    .busy(busy32), .w_enable(w_enable32), .result(result32),
    .ovf(ovf32), .err(err32)
  );

  fib_engine #(.W(8), .NW(32)) dut8 (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .init_n(init_n),
    .init_a(init_a[7:0]), .init_b(init_b[7:0]), .init_m(init_m[7:0]), .mode(mode),
    .busy(busy8), .w_enable(w_enable8), .result(result8),
    .ovf(ovf8), .err(err8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic start(input logic [31:0] n, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] m, input logic [1:0] md);
    @(negedge clk);
    init_n = n; init_a = a; init_b = b; init_m = m; mode = md;
    r_enable = 1'b1;
    @(posedge clk);
    #1;
    r_enable = 1'b0;
    init_n = $urandom; init_a = $urandom; init_b = $urandom; init_m = $urandom;
  endtask

  // Counts edges after the start edge until w_enable is seen; 0 if budget expires.
  task automatic wait_done(input int unsigned budget, output int unsigned cycles,
                           output logic busy_ok);
    cycles  = 0;
    busy_ok = 1'b1;
    for (int unsigned i = 0; i < budget; i++) begin
      if (!busy32) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      if (w_enable32) begin
        cycles = i + 1;
        if (!busy32) busy_ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic count_pulses(input int unsigned ncyc, output int unsigned pulses);
    pulses = 0;
    for (int unsigned i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      if (w_enable32) pulses++;
    end
  endtask

  initial begin
    int unsigned cyc, pulses;
    logic        bok;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy32, 0);
    check("rst_wen", w_enable32, 0);
    check("rst_result", result32, 0);
    check("rst_ovf", ovf32, 0);
    check("rst_err", err32, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // F10 = 55
    start(10, 0, 1, 0, 2'b00);
    wait_done(50, cyc, bok);
    check("fib10_latency", cyc, 11);
    check("fib10_result", result32, 55);
    check("fib10_ovf", ovf32, 0);
    check("fib10_err", err32, 0);
    check("fib10_busy", bok, 1);
    @(posedge clk); #1;
    check("fib10_pulse_end", w_enable32, 0);
    check("fib10_idle", busy32, 0);

    // n = 0 returns the seed a
    start(0, 7, 9, 0, 2'b00);
    wait_done(10, cyc, bok);
    check("n0_latency", cyc, 1);
    check("n0_result", result32, 7);
    @(posedge clk); #1;
    check("n0_pulse_end", w_enable32, 0);
    check("n0_result_hold", result32, 7);

    // 8-bit: F14 = 377 -> wraps to 121, saturates to 255
    start(14, 0, 1, 0, 2'b00);
    wait_done(50, cyc, bok);
    check("w8_wrap_result", result8, 121);
    check("w8_wrap_ovf", ovf8, 1);
    check("w8_wrap_32_result", result32, 377);
    check("w8_wrap_32_ovf", ovf32, 0);
    start(14, 0, 1, 0, 2'b01);
    wait_done(50, cyc, bok);
    check("w8_sat_result", result8, 255);
    check("w8_sat_ovf", ovf8, 1);

    // reserved mode behaves as wrap
    start(10, 0, 1, 0, 2'b11);
    wait_done(50, cyc, bok);
    check("mode11_result", result32, 55);

    // modular: 55 mod 7 = 6
    start(10, 0, 1, 7, 2'b10);
    wait_done(50, cyc, bok);
    check("mod_latency", cyc, 11);
    check("mod_result", result32, 6);
    check("mod_err", err32, 0);
    check("mod_ovf", ovf32, 0);
    // a >= m error
    start(10, 6, 1, 5, 2'b10);
    wait_done(50, cyc, bok);
    check("moderr_latency", cyc, 1);
    check("moderr_result", result32, 0);
    check("moderr_err", err32, 1);
    // m = 0 error
    start(3, 0, 0, 0, 2'b10);
    wait_done(50, cyc, bok);
    check("modm0_err", err32, 1);

    // restart mid-run: (2,3) -> 8 after 3 steps
    start(100, 1, 1, 0, 2'b00);
    repeat (5) @(posedge clk);
    start(3, 2, 3, 0, 2'b00);
    check("restart_err_cleared", err32, 0);
    wait_done(200, cyc, bok);
    check("restart_latency", cyc, 4);
    check("restart_result", result32, 8);
    count_pulses(120, pulses);
    check("restart_no_extra", pulses, 0);

    // restart on the would-be completion edge (E3 for n = 2)
    start(2, 100, 1, 0, 2'b00);
    repeat (2) @(posedge clk);
    start(1, 4, 6, 0, 2'b00);
    check("cancel_no_pulse", w_enable32, 0);
    check("cancel_result_held", result32, 8);
    wait_done(20, cyc, bok);
    check("cancel_latency", cyc, 2);
    check("cancel_result", result32, 6);

    // start in the w_enable cycle is accepted
    @(negedge clk);
    init_n = 1; init_a = 10; init_b = 20; mode = 2'b00; r_enable = 1'b1;
    @(posedge clk); #1;
    r_enable = 1'b0;
    wait_done(20, cyc, bok);
    start(0, 33, 0, 0, 2'b00);
    check("back2back_busy", busy32, 1);
    wait_done(20, cyc, bok);
    check("back2back_result", result32, 33);

    // reset mid-run with r_enable high
    start(50, 32'h8000_0000, 32'h8000_0000, 0, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    check("prerst_ovf", ovf32, 1);
    @(negedge clk);
    rst_n = 1'b0; r_enable = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", busy32, 0);
    check("midrst_wen", w_enable32, 0);
    check("midrst_result", result32, 0);
    check("midrst_ovf", ovf32, 0);
    check("midrst_err", err32, 0);
    @(negedge clk);
    rst_n = 1'b1; r_enable = 1'b0;
    count_pulses(70, pulses);
    check("midrst_no_completion", pulses, 0);
    check("midrst_idle", busy32, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
